// File: rtl/des_ctrl_pkg.sv
// Shared types and defaults for the DES job controller.
package des_ctrl_pkg;

  localparam int DES_DW      = 64;
  localparam int DES_TIMEOUT = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/des_rr_arb.sv
// Two-way round-robin arbiter: on a tie the requester not granted last wins.
module des_rr_arb (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = '0;
    if (req == 2'b11) begin
      gnt = last_grant ? 2'b01 : 2'b10;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/des_ctrl.sv
// Shares one external DES engine between two requesters, one job in flight,
// with a bounded wait for the engine result and per-requester responses.
module des_ctrl
  import des_ctrl_pkg::*;
#(
  parameter int TIMEOUT = DES_TIMEOUT,
  parameter int DW      = DES_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_vld,
  output logic          req0_rdy,
  input  logic [0:DW-1] req0_data,
  input  logic [0:DW-1] req0_key,
  input  logic          req1_vld,
  output logic          req1_rdy,
  input  logic [0:DW-1] req1_data,
  input  logic [0:DW-1] req1_key,
  output logic          rsp0_vld,
  input  logic          rsp0_rdy,
  output logic [0:DW-1] rsp0_data,
  output logic          rsp0_err,
  output logic          rsp1_vld,
  input  logic          rsp1_rdy,
  output logic [0:DW-1] rsp1_data,
  output logic          rsp1_err,
  output logic [0:DW-1] eng_data,
  output logic [0:DW-1] eng_key,
  output logic          eng_vld,
  input  logic [0:DW-1] eng_result,
  input  logic          eng_result_vld,
  output logic          busy
);

  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  state_t        state, state_nxt;
  logic          last_grant;
  logic          owner;
  logic          err_q;
  logic          rsp_take;
  logic [TW-1:0] timer;
  logic [1:0]    gnt;
  logic [0:DW-1] data_q, key_q, result_q;

  des_rr_arb u_arb (
    .req        ({req1_vld, req0_vld}),
    .last_grant (last_grant),
    .gnt        (gnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    req0_rdy  = 1'b0;
    req1_rdy  = 1'b0;
    rsp0_vld  = 1'b0;
    rsp1_vld  = 1'b0;
    eng_vld   = 1'b0;
    rsp_take  = 1'b0;
    case (state)
      IDLE: begin
        // state already reads IDLE during reset, so grants are gated explicitly
        if (!rst) begin
          req0_rdy = gnt[0];
          req1_rdy = gnt[1];
          if (|gnt) state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        eng_vld   = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (eng_result_vld || timer == TIMER_LAST) state_nxt = RESP;
      end
      RESP: begin
        rsp0_vld = !owner;
        rsp1_vld = owner;
        rsp_take = owner ? rsp1_rdy : rsp0_rdy;
        if (rsp_take) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
      owner      <= 1'b0;
      timer      <= '0;
      err_q      <= 1'b0;
      data_q     <= '0;
      key_q      <= '0;
      result_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|gnt) begin
            owner  <= gnt[1];
            data_q <= gnt[1] ? req1_data : req0_data;
            key_q  <= gnt[1] ? req1_key  : req0_key;
          end
        end
        ISSUE: timer <= '0;
        WAIT: begin
          if (timer != '1) timer <= timer + TW'(1);
          // a result arriving on the timeout cycle takes priority over the error
          if (eng_result_vld) begin
            result_q <= eng_result;
            err_q    <= 1'b0;
          end else if (timer == TIMER_LAST) begin
            result_q <= '0;
            err_q    <= 1'b1;
          end
        end
        RESP: if (rsp_take) last_grant <= owner;
        default: ;
      endcase
    end
  end

  assign eng_data  = data_q;
  assign eng_key   = key_q;
  assign rsp0_data = result_q;
  assign rsp1_data = result_q;
  assign rsp0_err  = rsp0_vld & err_q;
  assign rsp1_err  = rsp1_vld & err_q;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_des_ctrl.sv
// Scoreboard bench for des_ctrl with a behavioural engine (known-answer DES vector plus a keyed mix).
module tb_des_ctrl;

  localparam int DW = 64;
  localparam int TO = 32;
  localparam int ENG_LAT = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_vld, req0_rdy, req1_vld, req1_rdy;
  logic [0:DW-1] req0_data, req0_key, req1_data, req1_key;
  logic          rsp0_vld, rsp0_rdy, rsp0_err, rsp1_vld, rsp1_rdy, rsp1_err;
  logic [0:DW-1] rsp0_data, rsp1_data;
  logic [0:DW-1] eng_data, eng_key, eng_result;
  logic          eng_vld, eng_result_vld, busy;

  always #5 clk = ~clk;

  des_ctrl #(.TIMEOUT(TO), .DW(DW)) dut (
    .clk            (clk),
    .rst            (rst),
    .req0_vld       (req0_vld),
    .req0_rdy       (req0_rdy),
    .req0_data      (req0_data),
    .req0_key       (req0_key),
    .req1_vld       (req1_vld),
    .req1_rdy       (req1_rdy),
    .req1_data      (req1_data),
    .req1_key       (req1_key),
    .rsp0_vld       (rsp0_vld),
    .rsp0_rdy       (rsp0_rdy),
    .rsp0_data      (rsp0_data),
    .rsp0_err       (rsp0_err),
    .rsp1_vld       (rsp1_vld),
    .rsp1_rdy       (rsp1_rdy),
    .rsp1_data      (rsp1_data),
    .rsp1_err       (rsp1_err),
    .eng_data       (eng_data),
    .eng_key        (eng_key),
    .eng_vld        (eng_vld),
    .eng_result     (eng_result),
    .eng_result_vld (eng_result_vld),
    .busy           (busy)
  );

  typedef struct {
    logic        port;
    logic [63:0] data;
    logic [63:0] key;
  } job_t;

  typedef struct {
    logic        port;
    logic [63:0] data;
    logic        err;
  } rsp_t;

  job_t req_q0[$];
  job_t req_q1[$];
  job_t iss_q[$];
  rsp_t rsp_q[$];
  job_t cur;
  rsp_t rexp;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] enc_model(input logic [63:0] d, input logic [63:0] k);
    if (d == 64'h0123456789ABCDEF && k == 64'h133457799BBCDFF1) return 64'h85E813540F0AB405;
    return {d[40:0], d[63:41]} ^ k ^ 64'hC3A5_5A3C_0FF0_9669;
  endfunction

  // Behavioural engine: not reset, restarts on every eng_vld.
  int          eng_cnt = 0;
  logic        eng_pulse = 1'b0;
  logic        inj_pulse = 1'b0;
  bit          eng_mute = 1'b0;
  logic [63:0] eng_res_q = '0;

  always @(posedge clk) begin
    eng_pulse <= 1'b0;
    if (eng_vld) begin
      eng_cnt   <= ENG_LAT;
      eng_res_q <= enc_model(eng_data, eng_key);
    end else if (eng_cnt > 0) begin
      eng_cnt <= eng_cnt - 1;
      if (eng_cnt == 1 && !eng_mute) eng_pulse <= 1'b1;
    end
  end

  assign eng_result_vld = eng_pulse | inj_pulse;
  assign eng_result     = eng_res_q;

  initial begin : drv0
    req0_vld = 1'b0; req0_data = '0; req0_key = '0;
    forever begin
      @(posedge clk); #1;
      if (req_q0.size() > 0) begin
        req0_vld = 1'b1; req0_data = req_q0[0].data; req0_key = req_q0[0].key;
        @(negedge clk);
        if (req0_rdy) begin
          @(posedge clk); #1;
          void'(req_q0.pop_front());
          req0_vld = 1'b0;
        end
      end else begin
        req0_vld = 1'b0;
      end
    end
  end

  initial begin : drv1
    req1_vld = 1'b0; req1_data = '0; req1_key = '0;
    forever begin
      @(posedge clk); #1;
      if (req_q1.size() > 0) begin
        req1_vld = 1'b1; req1_data = req_q1[0].data; req1_key = req_q1[0].key;
        @(negedge clk);
        if (req1_rdy) begin
          @(posedge clk); #1;
          void'(req_q1.pop_front());
          req1_vld = 1'b0;
        end
      end else begin
        req1_vld = 1'b0;
      end
    end
  end

  initial begin : monitor
    int unsigned eng_run;
    eng_run = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (req0_rdy || req1_rdy) begin
          check("grant_onehot", req0_rdy & req1_rdy, 0);
          if (iss_q.size() == 0) check("grant_unexpected", 1, 0);
          else begin
            cur = iss_q.pop_front();
            check("grant_port", req1_rdy, cur.port);
          end
        end
        if (eng_vld) begin
          eng_run++;
          check("eng_vld_width", eng_run, 1);
          check("eng_data", eng_data, cur.data);
          check("eng_key", eng_key, cur.key);
        end else begin
          eng_run = 0;
        end
        if (rsp0_vld || rsp1_vld) check("rsp_vld_onehot", rsp0_vld & rsp1_vld, 0);
        if ((rsp0_vld && rsp0_rdy) || (rsp1_vld && rsp1_rdy)) begin
          if (rsp_q.size() == 0) check("rsp_unexpected", 1, 0);
          else begin
            rexp = rsp_q.pop_front();
            check("rsp_port", rsp1_vld, rexp.port);
            check("rsp_data", rsp1_vld ? rsp1_data : rsp0_data, rexp.data);
            check("rsp_err", rsp1_vld ? rsp1_err : rsp0_err, rexp.err);
          end
        end
      end
    end
  end

  task automatic add_job(input logic port, input logic [63:0] d, input logic [63:0] k,
                         input bit want_rsp, input bit want_err);
    job_t j;
    rsp_t r;
    j.port = port; j.data = d; j.key = k;
    if (port) req_q1.push_back(j);
    else      req_q0.push_back(j);
    iss_q.push_back(j);
    if (want_rsp) begin
      r.port = port;
      r.data = want_err ? 64'h0 : enc_model(d, k);
      r.err  = want_err;
      rsp_q.push_back(r);
    end
  endtask

  // which: 0 = eng_vld, 1 = any rsp_vld; n = negedges elapsed
  task automatic wait_sig(input int which, input int budget, input string tag, output int n);
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      if ((which == 0 && eng_vld) || (which == 1 && (rsp0_vld || rsp1_vld))) break;
      if (n >= budget) begin
        check(tag, 1, 0);
        break;
      end
    end
  endtask

  task automatic wait_drain(input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (rsp_q.size() == 0 && req_q0.size() == 0 && req_q1.size() == 0 && !busy) return;
    end
    check(tag, 1, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin : main
    int n;
    int quiet;
    rst = 1'b1; rsp0_rdy = 1'b1; rsp1_rdy = 1'b1;

    // Known-answer job queued while in reset: must not be granted yet
    add_job(1'b0, 64'h0123456789ABCDEF, 64'h133457799BBCDFF1, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req0_vld_seen", req0_vld, 1);
    check("rst_req0_rdy", req0_rdy, 0);
    check("rst_busy", busy, 0);
    check("rst_eng_vld", eng_vld, 0);
    check("rst_rsp0_vld", rsp0_vld, 0);
    check("rst_rsp1_vld", rsp1_vld, 0);
    check("rst_rsp0_err", rsp0_err, 0);
    check("rst_eng_data", eng_data, 0);
    check("rst_eng_key", eng_key, 0);
    check("rst_rsp0_data", rsp0_data, 0);
    @(posedge clk); #1 rst = 1'b0;
    wait_drain(200, "kat_drain_timeout");

    // Tie after reset: grant order 0,1,0,1
    do_reset();
    for (int i = 0; i < 2; i++) begin
      add_job(1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 1'b0);
      add_job(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 1'b0);
    end
    wait_drain(400, "tie_drain_timeout");

    // Timeout: engine silent, error response 32 cycles after entering WAIT
    eng_mute = 1'b1;
    add_job(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 1'b1);
    wait_sig(0, 50, "to_issue_timeout", n);
    wait_sig(1, TO + 10, "to_rsp_timeout", n);
    check("wait_to_err", n, TO + 1);
    repeat (5) @(posedge clk);
    #1 inj_pulse = 1'b1;
    @(posedge clk); #1 inj_pulse = 1'b0;
    quiet = 0;
    repeat (20) begin
      @(negedge clk);
      if (rsp0_vld || rsp1_vld || busy) quiet++;
    end
    check("late_result_ignored", quiet, 0);
    eng_mute = 1'b0;

    // Backpressure on response 1 with requester 0 waiting
    rsp1_rdy = 1'b0;
    add_job(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 1'b0);
    wait_sig(1, 60, "bp_rsp_timeout", n);
    add_job(1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 1'b0);
    repeat (10) begin
      @(negedge clk);
      check("bp_rsp1_vld", rsp1_vld, 1);
      check("bp_rsp1_data", rsp1_data, rsp_q[0].data);
      check("bp_req0_rdy", req0_rdy, 0);
      check("bp_busy", busy, 1);
    end
    @(posedge clk); #1 rsp1_rdy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_idle_busy", busy, 0);
    check("bp_idle_req0_rdy", req0_rdy, 1);
    wait_drain(200, "bp_drain_timeout");

    // Reset 8 cycles into WAIT: job abandoned, late engine result ignored
    add_job(1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b0);
    wait_sig(0, 50, "rw_issue_timeout", n);
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("rw_busy", busy, 0);
    check("rw_eng_vld", eng_vld, 0);
    check("rw_rsp0_vld", rsp0_vld, 0);
    check("rw_rsp1_vld", rsp1_vld, 0);
    check("rw_eng_data", eng_data, 0);
    check("rw_eng_key", eng_key, 0);
    check("rw_rsp0_data", rsp0_data, 0);
    @(posedge clk); #1 rst = 1'b0;
    quiet = 0;
    repeat (20) begin
      @(negedge clk);
      if (rsp0_vld || rsp1_vld || busy) quiet++;
    end
    check("rw_result_ignored", quiet, 0);
    check("iss_q_left", iss_q.size(), 0);
    check("rsp_q_left", rsp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/des_ctrl.md
DES_CTRL -- requirements
Module: des_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 32, giving the maximum number of cycles spent waiting for an engine result before an error response.
REQ-002 The block SHALL have parameter DW, default 64, giving the data and key width, bit 0 = MSB, matching the DES engine bit order.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-004 The port list SHALL be, clock and reset first:
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous active-high reset
- req0_vld  in  1  requester 0 has a job
- req0_rdy  out  1  job 0 accepted this cycle
- req0_data  in  DW  plaintext/ciphertext for requester 0
- req0_key  in  DW  key for requester 0
- req1_vld, req1_rdy, req1_data, req1_key  same as requester 0, for requester 1
- rsp0_vld  out  1  response 0 valid
- rsp0_rdy  in  1  response 0 taken
- rsp0_data  out  DW  result for requester 0
- rsp0_err  out  1  response 0 is a timeout
- rsp1_vld, rsp1_rdy, rsp1_data, rsp1_err  same as response 0, for requester 1
- eng_data  out  DW  engine data input
- eng_key  out  DW  engine key input
- eng_vld  out  1  one-cycle start pulse to the engine
- eng_result  in  DW  engine result
- eng_result_vld  in  1  engine result pulse
- busy  out  1  FSM not in IDLE

Function
REQ-005 The FSM SHALL have the states IDLE, ISSUE, WAIT and RESP, with exactly one job in flight at a time.
REQ-006 IDLE: the 2-way round-robin arbiter SHALL select among valid requests, assert the winner's reqN_rdy combinationally in that cycle, and capture data, key and the owner id, then go to ISSUE. The loser's rdy SHALL stay 0.
REQ-007 Round-robin: on simultaneous requests the requester not granted last SHALL win. last_grant SHALL reset to 1, so requester 0 wins the first tie.
REQ-008 ISSUE: eng_vld SHALL be 1 for exactly one cycle with eng_data and eng_key driven from the captured registers, then the FSM goes to WAIT.
REQ-009 eng_data and eng_key SHALL hold their captured values through WAIT. The engine restarts on any eng_vld, so eng_vld SHALL NOT be asserted outside ISSUE.
REQ-010 WAIT: the timer SHALL clear on entry and increment each cycle. When eng_result_vld=1, eng_result SHALL be captured with err=0 and the FSM goes to RESP.
REQ-011 WAIT: if the timer reaches TIMEOUT-1 with no eng_result_vld, the FSM SHALL go to RESP with err=1 and data all-zero. If eng_result_vld arrives in that same cycle, the result SHALL win (err=0).
REQ-012 eng_result_vld SHALL be ignored in IDLE, ISSUE and RESP; this covers late results after a timeout and the engine's unreset power-up state.
REQ-013 Behaviour SHALL NOT depend on exact engine latency; the nominal latency is 16 cycles after the eng_vld edge.
REQ-014 RESP: only the owner's rspN_vld SHALL be 1, with rspN_data and rspN_err held stable until rspN_rdy=1.
REQ-015 On the handshake cycle in RESP, last_grant SHALL be set to the owner id and the FSM goes to IDLE. A new grant SHALL NOT occur before the following cycle.
REQ-016 rspN_vld SHALL never be 1 for both ports at once, and reqN_rdy SHALL be 0 in every state except IDLE.
REQ-017 Timer width SHALL be $clog2(TIMEOUT)+1 bits, and the timer SHALL never wrap.

Reset
REQ-018 While rst=1, the FSM SHALL be in IDLE, last_grant=1 and timer=0.
REQ-019 While rst=1, all rdy, rsp_vld, rsp_err, eng_vld and busy outputs SHALL be 0, and the data/key/result registers SHALL be 0.
REQ-020 A reset mid-job SHALL abandon the job with no response. Any later engine result_vld SHALL be ignored per REQ-012.

Structure
REQ-021 Package des_ctrl_pkg SHALL hold the state enum (IDLE/ISSUE/WAIT/RESP), the DW constant and the default TIMEOUT.
REQ-022 The arbiter SHALL be sub-module des_rr_arb: inputs req[1:0] and last_grant; outputs gnt[1:0] (one-hot or zero), combinational.
REQ-023 The encrypt engine SHALL be instantiated outside des_ctrl; the bench connects a behavioural engine or the real DES core.

Verification
REQ-024 Single job: req0 with data 0x0123456789ABCDEF, key 0x133457799BBCDFF1, real encrypt core, rsp0_rdy=1 -> rsp0_data=0x85E813540F0AB405, err=0, eng_vld pulse width 1.
REQ-025 Tie after reset: req0 and req1 both held -> grants in order 0,1,0,1 over four jobs, with each response routed to the correct port.
REQ-026 Timeout: model engine never returns, TIMEOUT=32 -> rsp_err=1 and data=0 exactly 32 cycles after entering WAIT. A late eng_result_vld 5 cycles later -> no response.
REQ-027 Backpressure: rsp1_rdy held 0 for 10 cycles -> rsp1_vld and data stable, req0_rdy stays 0, busy=1. Releasing rdy -> IDLE next cycle.
REQ-028 Reset in WAIT: assert rst 8 cycles into WAIT -> all outputs 0 immediately. The engine result arriving after deassert -> ignored, busy=0.
